// File: rtl/accum_pkg.sv
// Shared types and defaults for the n-bit accumulator and its operand sequencer.
package accum_pkg;

  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned ACC_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with no bypass: a written word is readable the cycle after it is pushed.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/accum_seq_nbits.sv
// Operand sequencer: buffers producer words and feeds len of them to the accumulator per burst.
module accum_seq_nbits
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = ACC_LEN_W
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [WIDTH-1:0] x_o,
  output logic             acc_clr_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;

  assign in_ready_o = !full;
  assign push       = in_valid_i && !full;
  assign pop        = (state == ST_RUN) && !empty;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (nrst_i),
    .push  (push),
    .pop   (pop),
    .wdata (in_data_i),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs are registered alongside the state they belong to, so they
  // are valid for exactly the cycle the FSM spends in that state.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      x_o       <= '0;
      acc_clr_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      x_o       <= '0;
      acc_clr_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            len_q     <= len_i;
            cnt       <= '0;
            state     <= ST_CLEAR;
            acc_clr_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (len_q == '0) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pop) begin
            x_o <= head;
            cnt <= cnt + LEN_W'(1);
            if (cnt + LEN_W'(1) == len_q) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
